// File: rtl/prog_cntr_sel_ctrl_if.sv
// Bundle of the control signals exchanged between fetch-stage control sources
// and the PC load-select controller.
//   master : drives the control events (stall, branch/call/return, interrupt
//            requests, sequential PC) and observes the select outputs.
//   slave  : the selector itself; consumes the events and drives the mux
//            select, return/interrupt addresses and status flags.
interface prog_cntr_sel_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 14
);
  logic                  stall;
  logic                  branch_taken;
  logic                  call;
  logic                  ret;
  logic                  reti;
  logic                  ei;
  logic                  di;
  logic                  int_req;
  logic [ADDR_WIDTH-1:0] next_prog_cntr;

  logic [3:0]            sel_signals;
  logic [ADDR_WIDTH-1:0] ret_addr;
  logic [ADDR_WIDTH-1:0] int_branch_addr;
  logic                  pc_load_en;
  logic                  flush;
  logic                  int_enabled;
  logic                  in_isr;
  logic                  stack_overflow;
  logic                  stack_underflow;

  modport master (
    output stall, branch_taken, call, ret, reti, ei, di, int_req, next_prog_cntr,
    input  sel_signals, ret_addr, int_branch_addr, pc_load_en, flush, int_enabled,
           in_isr, stack_overflow, stack_underflow
  );

  modport slave (
    input  stall, branch_taken, call, ret, reti, ei, di, int_req, next_prog_cntr,
    output sel_signals, ret_addr, int_branch_addr, pc_load_en, flush, int_enabled,
           in_isr, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/prog_cntr_sel_ctrl.sv
// Fetch-stage PC load-select controller.
// Arbitrates next / branch / interrupt / return each cycle, producing the
// one-hot select for the PC load mux ([0] branch, [1] next, [2] interrupt,
// [3] return), keeps a hardware return-address stack, and tracks the
// interrupt-enable and ISR state.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset
//   bus    - prog_cntr_sel_ctrl_if.slave (control inputs, select/status outputs)
// Optional build macro PC_SEL_NESTED_INT_EN: allows interrupts to be taken
// while already in the ISR (when re-enabled with ei); a nesting counter keeps
// the ISR state until the outermost reti.
module prog_cntr_sel_ctrl #(
  parameter int unsigned           ADDR_WIDTH  = 14,
  parameter int unsigned           STACK_DEPTH = 8,
  parameter logic [ADDR_WIDTH-1:0] INT_VECTOR  = 14'h0004
) (
  input logic                clock,
  input logic                reset,
  prog_cntr_sel_ctrl_if.slave bus
);

  localparam int unsigned IdxW = $clog2(STACK_DEPTH);
  localparam int unsigned PtrW = IdxW + 1;
  localparam logic [PtrW-1:0] PtrFull = PtrW'(STACK_DEPTH);

  localparam logic [3:0] SelBranch = 4'b0001;
  localparam logic [3:0] SelNext   = 4'b0010;
  localparam logic [3:0] SelInt    = 4'b0100;
  localparam logic [3:0] SelRet    = 4'b1000;

  typedef enum logic {StRun, StIsr} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [PtrW-1:0]       sp_q, sp_d;
  logic                  pend_q, pend_d;
  logic                  ie_q, ie_d;
  logic                  flush_q, flush_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  state_ok;
  logic                  take;
  logic                  do_push;
  logic                  do_pop;
  logic                  stack_full;
  logic                  stack_empty;
  logic [IdxW-1:0]       top_idx;
  logic [3:0]            sel;

`ifdef PC_SEL_NESTED_INT_EN
  // Number of interrupts taken on top of the outermost one.
  logic [PtrW-1:0]       depth_q, depth_d;
`endif

  assign stack_full  = (sp_q == PtrFull);
  assign stack_empty = (sp_q == '0);
  // Low bits wrap correctly when full (DEPTH -> index DEPTH-1).
  assign top_idx     = sp_q[IdxW-1:0] - IdxW'(1);

`ifdef PC_SEL_NESTED_INT_EN
  assign state_ok = 1'b1;
`else
  assign state_ok = (state_q == StRun);
`endif

  // Interrupts only go in on a sequential cycle; they never preempt control flow.
  assign take = pend_q & ie_q & state_ok & ~bus.branch_taken & ~bus.ret & ~bus.reti &
                ~bus.stall;

  always_comb begin
    sel = SelNext;
    if (bus.stall)                 sel = SelNext;
    else if (bus.ret || bus.reti)  sel = SelRet;
    else if (bus.branch_taken)     sel = SelBranch;
    else if (take)                 sel = SelInt;
  end

  // ret/reti outrank a linking call in the same cycle; take already excludes them.
  assign do_pop  = ~bus.stall & (bus.ret | bus.reti);
  assign do_push = ~bus.stall & ((bus.call & bus.branch_taken & ~bus.ret & ~bus.reti) | take);

  always_comb begin
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    pend_d  = pend_q;
    ie_d    = ie_q;
    state_d = state_q;
    flush_d = ~bus.stall & (sel != SelNext);
`ifdef PC_SEL_NESTED_INT_EN
    depth_d = depth_q;
`endif

    if (!bus.stall) begin
      if (do_pop) begin
        if (stack_empty) unf_d = 1'b1;
        else             sp_d  = sp_q - PtrW'(1);
      end else if (do_push) begin
        if (stack_full)  ovf_d = 1'b1;
        else             sp_d  = sp_q + PtrW'(1);
      end

      // A request arriving in the take cycle stays pending.
      pend_d = bus.int_req | (pend_q & ~take);

      if (take)          ie_d = 1'b0;
      else if (bus.reti) ie_d = 1'b1;
      else if (bus.di)   ie_d = 1'b0;
      else if (bus.ei)   ie_d = 1'b1;

      unique case (state_q)
        StRun: begin
          if (take) state_d = StIsr;
        end
        StIsr: begin
`ifdef PC_SEL_NESTED_INT_EN
          if (take) begin
            if (depth_q != '1) depth_d = depth_q + PtrW'(1);
          end else if (bus.reti) begin
            if (depth_q == '0) state_d = StRun;
            else               depth_d = depth_q - PtrW'(1);
          end
`else
          if (bus.reti) state_d = StRun;
`endif
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      sp_q    <= '0;
      pend_q  <= 1'b0;
      ie_q    <= 1'b0;
      flush_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`ifdef PC_SEL_NESTED_INT_EN
      depth_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      pend_q  <= pend_d;
      ie_q    <= ie_d;
      flush_q <= flush_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`ifdef PC_SEL_NESTED_INT_EN
      depth_q <= depth_d;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(STACK_DEPTH); i++) stack_q[i] <= '0;
    end else if (do_push && !do_pop && !stack_full) begin
      stack_q[sp_q[IdxW-1:0]] <= bus.next_prog_cntr;
    end
  end

  assign bus.sel_signals     = sel;
  assign bus.ret_addr        = stack_empty ? '0 : stack_q[top_idx];
  assign bus.int_branch_addr = INT_VECTOR;
  assign bus.pc_load_en      = ~bus.stall;
  assign bus.flush           = flush_q;
  assign bus.int_enabled     = ie_q;
  assign bus.in_isr          = (state_q == StIsr);
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;

endmodule

// File: tb/tb_prog_cntr_sel_ctrl.sv
module tb_prog_cntr_sel_ctrl;
  localparam int unsigned AW    = 14;
  localparam int unsigned DEPTH = 8;
  localparam logic [AW-1:0] IVEC = 14'h0004;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  prog_cntr_sel_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  prog_cntr_sel_ctrl #(
    .ADDR_WIDTH (AW),
    .STACK_DEPTH(DEPTH),
    .INT_VECTOR (IVEC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Reference model: plain queue stack plus flags.
  logic [AW-1:0] m_stk[$];
  bit            m_pend, m_ie, m_flush, m_ovf, m_unf;
  int            m_lvl;  // interrupt nesting level, 0 = not in ISR

  function automatic bit m_take();
    bit allowed;
`ifdef PC_SEL_NESTED_INT_EN
    allowed = 1'b1;
`else
    allowed = (m_lvl == 0);
`endif
    return m_pend && m_ie && allowed && !bus.branch_taken && !bus.ret && !bus.reti &&
           !bus.stall;
  endfunction

  function automatic logic [3:0] m_sel();
    if (bus.stall)               return 4'b0010;
    if (bus.ret || bus.reti)     return 4'b1000;
    if (bus.branch_taken)        return 4'b0001;
    if (m_take())                return 4'b0100;
    return 4'b0010;
  endfunction

  function automatic logic [AW-1:0] m_top();
    if (m_stk.size() == 0) return '0;
    return m_stk[m_stk.size()-1];
  endfunction

  task automatic model_clock();
    logic [3:0] s;
    bit tk;
    s  = m_sel();
    tk = m_take();
    m_flush = !bus.stall && (s != 4'b0010);
    if (bus.stall) return;
    if (bus.ret || bus.reti) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else void'(m_stk.pop_back());
    end else if ((bus.call && bus.branch_taken) || tk) begin
      if (m_stk.size() == DEPTH) m_ovf = 1'b1;
      else m_stk.push_back(bus.next_prog_cntr);
    end
    m_pend = bus.int_req || (m_pend && !tk);
    if (tk) begin
      m_ie = 1'b0;
      m_lvl++;
    end else if (bus.reti) begin
      m_ie = 1'b1;
      if (m_lvl > 0) m_lvl--;
    end else if (bus.di) m_ie = 1'b0;
    else if (bus.ei) m_ie = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.branch_taken = 0; bus.call = 0; bus.ret = 0; bus.reti = 0;
    bus.ei = 0; bus.di = 0; bus.int_req = 0;
    bus.next_prog_cntr = AW'($urandom);
  endtask

  // Advance one clock, keep the model in step, settle past the edge.
  task automatic step();
    @(posedge clock);
    model_clock();
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #1;
    idle_inputs();
    reset = 1'b1;
    #2;
    m_stk.delete();
    m_pend = 0; m_ie = 0; m_flush = 0; m_ovf = 0; m_unf = 0; m_lvl = 0;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] flags;
    apply_reset();
    total++;
    if (bus.sel_signals !== 4'b0010) begin
      bad++; $display("FAIL reset_sel: got %b want 0010", bus.sel_signals);
    end
    total++;
    if (bus.ret_addr !== '0) begin
      bad++; $display("FAIL reset_ret_addr: got %h want 0", bus.ret_addr);
    end
    flags = {bus.flush, bus.int_enabled, bus.in_isr, bus.stack_overflow,
             bus.stack_underflow, bus.pc_load_en, 2'b00};
    total++;
    if (flags !== 8'b0000_0100) begin
      bad++; $display("FAIL reset_flags: got %b want 00000100", flags);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (bus.flush !== 1'b0) begin
        bad++; $display("FAIL idle_flush cycle %0d: got %b want 0", i, bus.flush);
      end
    end
  endtask

  task automatic test_call_ret();
    apply_reset();
    bus.call = 1; bus.branch_taken = 1; bus.next_prog_cntr = 14'h0123;
    #1;
    total++;
    if (bus.sel_signals !== 4'b0001) begin
      bad++; $display("FAIL call_sel: got %b want 0001", bus.sel_signals);
    end
    step();
    idle_inputs();
    #1;
    total++;
    if ({bus.flush, bus.ret_addr} !== {1'b1, 14'h0123}) begin
      bad++; $display("FAIL call_push: got flush=%b ret=%h want 1 0123", bus.flush, bus.ret_addr);
    end
    bus.ret = 1;
    #1;
    total++;
    if (bus.sel_signals !== 4'b1000) begin
      bad++; $display("FAIL ret_sel: got %b want 1000", bus.sel_signals);
    end
    step();
    idle_inputs();
    #1;
    total++;
    if ({bus.flush, bus.ret_addr} !== {1'b1, 14'h0000}) begin
      bad++; $display("FAIL ret_pop: got flush=%b ret=%h want 1 0000", bus.flush, bus.ret_addr);
    end
  endtask

  task automatic test_interrupt();
    logic [AW-1:0] link;
    apply_reset();
    bus.ei = 1;
    step();
    idle_inputs();
    bus.int_req = 1;
    #1;
    total++;
    if (bus.sel_signals !== 4'b0010) begin
      bad++; $display("FAIL int_req_cycle_sel: got %b want 0010", bus.sel_signals);
    end
    step();
    idle_inputs();
    link = bus.next_prog_cntr;
    #1;
    total++;
    if ({bus.sel_signals, bus.int_branch_addr} !== {4'b0100, IVEC}) begin
      bad++; $display("FAIL int_take: got sel=%b vec=%h want 0100 0004",
                      bus.sel_signals, bus.int_branch_addr);
    end
    step();
    idle_inputs();
    #1;
    total++;
    if ({bus.in_isr, bus.int_enabled, bus.ret_addr} !== {2'b10, link}) begin
      bad++; $display("FAIL isr_entry: got isr=%b ie=%b ret=%h want 1 0 %h",
                      bus.in_isr, bus.int_enabled, bus.ret_addr, link);
    end
    bus.reti = 1;
    #1;
    total++;
    if (bus.sel_signals !== 4'b1000) begin
      bad++; $display("FAIL reti_sel: got %b want 1000", bus.sel_signals);
    end
    step();
    idle_inputs();
    #1;
    total++;
    if ({bus.in_isr, bus.int_enabled, bus.ret_addr} !== {2'b01, 14'h0}) begin
      bad++; $display("FAIL isr_exit: got isr=%b ie=%b ret=%h want 0 1 0000",
                      bus.in_isr, bus.int_enabled, bus.ret_addr);
    end
  endtask

  task automatic test_defer();
    apply_reset();
    bus.ei = 1;
    step();
    idle_inputs();
    bus.int_req = 1;
    for (int i = 0; i < 3; i++) begin
      bus.branch_taken = 1;
      #1;
      total++;
      if (bus.sel_signals !== 4'b0001) begin
        bad++; $display("FAIL defer_branch %0d: got %b want 0001", i, bus.sel_signals);
      end
      step();
      idle_inputs();
    end
    #1;
    total++;
    if (bus.sel_signals !== 4'b0100) begin
      bad++; $display("FAIL defer_take: got %b want 0100", bus.sel_signals);
    end
    step();
  endtask

  task automatic test_overflow();
    logic [AW-1:0] want;
    apply_reset();
    for (int i = 1; i <= 9; i++) begin
      bus.call = 1; bus.branch_taken = 1; bus.next_prog_cntr = AW'(i);
      step();
      idle_inputs();
    end
    #1;
    total++;
    if ({bus.stack_overflow, bus.ret_addr} !== {1'b1, 14'd8}) begin
      bad++; $display("FAIL overflow: got ovf=%b ret=%h want 1 0008",
                      bus.stack_overflow, bus.ret_addr);
    end
    for (int k = 1; k <= 9; k++) begin
      bus.ret = 1;
      #1;
      want = (k <= 8) ? AW'(9 - k) : '0;
      total++;
      if ({bus.sel_signals, bus.ret_addr} !== {4'b1000, want}) begin
        bad++; $display("FAIL ret_chain %0d: got sel=%b ret=%h want 1000 %h",
                        k, bus.sel_signals, bus.ret_addr, want);
      end
      step();
      idle_inputs();
    end
    #1;
    total++;
    if ({bus.stack_underflow, bus.ret_addr} !== {1'b1, 14'h0}) begin
      bad++; $display("FAIL underflow: got unf=%b ret=%h want 1 0000",
                      bus.stack_underflow, bus.ret_addr);
    end
  endtask

  task automatic test_stall();
    logic [AW-1:0] link;
    apply_reset();
    link = AW'($urandom_range(1, 16'h3fff));
    bus.call = 1; bus.branch_taken = 1; bus.next_prog_cntr = link;
    step();
    bus.stall = 1;
    bus.next_prog_cntr = ~link;
    #1;
    total++;
    if ({bus.pc_load_en, bus.sel_signals} !== {1'b0, 4'b0010}) begin
      bad++; $display("FAIL stall_sel: got en=%b sel=%b want 0 0010",
                      bus.pc_load_en, bus.sel_signals);
    end
    step();
    idle_inputs();
    #1;
    total++;
    if ({bus.flush, bus.ret_addr} !== {1'b0, link}) begin
      bad++; $display("FAIL stall_hold: got flush=%b ret=%h want 0 %h",
                      bus.flush, bus.ret_addr, link);
    end
  endtask

  task automatic test_random();
    logic [AW+9:0] got, want;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      bus.stall        = ($urandom_range(0, 9) == 0);
      bus.branch_taken = ($urandom_range(0, 4) == 0);
      bus.call         = bus.branch_taken && $urandom_range(0, 1) == 1;
      bus.ret          = ($urandom_range(0, 11) == 0);
      bus.reti         = ($urandom_range(0, 11) == 0);
      bus.ei           = ($urandom_range(0, 5) == 0);
      bus.di           = ($urandom_range(0, 19) == 0);
      bus.int_req      = ($urandom_range(0, 5) == 0);
      bus.next_prog_cntr = AW'($urandom);
      if (c == 300) begin
        apply_reset();
      end
      #1;
      got  = {bus.sel_signals, bus.ret_addr, bus.pc_load_en, bus.flush, bus.int_enabled,
              bus.in_isr, bus.stack_overflow, bus.stack_underflow};
      want = {m_sel(), m_top(), !bus.stall, m_flush, m_ie, (m_lvl != 0), m_ovf, m_unf};
      total++;
      if (got !== want || bus.int_branch_addr !== IVEC) begin
        bad++; $display("FAIL random cycle %0d: got %h want %h (vec %h)",
                        c, got, want, bus.int_branch_addr);
      end
      step();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_call_ret();
    test_interrupt();
    test_defer();
    test_overflow();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_cntr_sel_ctrl.md
Name: prog_cntr_sel_ctrl

Overview:
- Control-side partner of the fetch-stage program-counter load mux.
- Each cycle, produces the one-hot select vector that mux consumes, the return address it consumes (top of a hardware return-address stack), and the interrupt vector.
- Arbitrates next/branch/interrupt/return events, maintains the return stack on call/interrupt/return, and tracks interrupt enable and ISR state.
- Sits in the fetch stage between decode/branch-resolution control and the PC load mux.

Parameters:
- ADDR_WIDTH, 14, program address width.
- STACK_DEPTH, 8, return stack entries (power of two, >=2).
- INT_VECTOR, 14'h0004, interrupt branch target.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC; suppresses all state updates.
- branch_taken  input  1  resolved taken branch or jump.
- call  input  1  taken branch that links; asserted together with branch_taken.
- ret  input  1  subroutine return.
- reti  input  1  interrupt return.
- ei  input  1  set interrupt enable.
- di  input  1  clear interrupt enable.
- int_req  input  1  interrupt request pulse or level.
- next_prog_cntr  input  ADDR_WIDTH  sequential PC; this is the link value pushed.
- sel_signals  output  4  one-hot: [0] branch, [1] next, [2] interrupt, [3] return.
- ret_addr  output  ADDR_WIDTH  top of stack; 0 when empty.
- int_branch_addr  output  ADDR_WIDTH  constant INT_VECTOR.
- pc_load_en  output  1  equals ~stall.
- flush  output  1  registered pulse, one cycle after any non-sequential select.
- int_enabled  output  1  current interrupt enable flag.
- in_isr  output  1  ISR state flag.
- stack_overflow  output  1  sticky error flag.
- stack_underflow  output  1  sticky error flag.

Behaviour:
- Reset (async):
  - Stack pointer = 0; all entries = 0.
  - int_pending = 0, ie = 0, state = RUN.
  - flush = 0, stack_overflow = 0, stack_underflow = 0.
  - Combinational outputs after reset: sel_signals = 4'b0010, ret_addr = 0.
- sel_signals is combinational, exactly one bit set at all times, fixed priority:
  - stall -> 0010.
  - else ret|reti -> 1000.
  - else branch_taken -> 0001.
  - else interrupt take -> 0100.
  - else 0010.
- Interrupt take condition: int_pending & ie & state==RUN & ~branch_taken & ~ret & ~reti & ~stall. Interrupts never preempt a control-flow event; they wait for the next sequential cycle.
- int_pending: set on int_req; cleared on take. If int_req and take occur in the same cycle, pending stays set.
- State machine:
  - RUN -> ISR on interrupt take. On take: push next_prog_cntr, clear ie.
  - ISR -> RUN on reti (not stalled). On reti: pop, set ie.
  - ret in ISR pops but stays in ISR.
- ie: ei sets, di clears; di wins if both. Take and reti override ei/di in their cycle.
- Stack:
  - Push on (call & branch_taken & ~ret & ~reti) or interrupt take.
  - Pop on ret|reti.
  - All stack ops gated by ~stall.
  - call together with ret/reti: ret wins, no push.
  - ret_addr reflects the top entry combinationally and updates the cycle after a push or pop.
- Boundaries:
  - Push when full (STACK_DEPTH entries): push dropped, stack_overflow set.
  - Pop when empty: ret_addr = 0 is still selected, pointer stays 0, stack_underflow set.
  - Error flags clear only on reset.
- flush <= ~stall & (sel_signals != 0010), registered, 1-cycle latency.
- Reset mid-ISR returns to RUN with ie = 0; the stack is lost.

Optional Feature:
- Macro: PC_SEL_NESTED_INT_EN.
- Defined: interrupts may be taken in ISR state when ie = 1 (set by ei inside the ISR). Each nested take pushes and stays in ISR. An in-ISR nesting depth counter is added; reti decrements it and returns to RUN only at zero.
- Undefined: ISR state blocks interrupt takes regardless of ie.

Test Plan:
- Reset, then idle -> sel_signals = 0010, ret_addr = 0, all flags 0; flush = 0 across 5 cycles.
- call+branch_taken with next_prog_cntr = 14'h0123 -> sel = 0001, flush = 1 next cycle, ret_addr = 14'h0123. Then ret -> sel = 1000, ret_addr becomes 0 next cycle.
- ei, int_req pulse, no branches -> sel = 0100 one cycle after the request (int_branch_addr = 14'h0004), in_isr = 1, int_enabled = 0, ret_addr = pushed next_prog_cntr. Then reti -> sel = 1000, in_isr = 0, int_enabled = 1.
- int_req while branch_taken held for 3 cycles -> interrupt deferred; sel = 0100 on the first cycle branch_taken drops.
- 9 consecutive calls (STACK_DEPTH = 8) with addresses 1..9 -> stack_overflow = 1, ret_addr = 8. Then 9 rets -> the ninth loads 0 and sets stack_underflow.
- stall held together with call+branch_taken -> pc_load_en = 0, sel = 0010, no push (ret_addr unchanged), flush = 0.
